// File: rtl/sb_cfg_mux_array.sv
// Switch-block routing core: NUM_OUT binary-select muxes over in_bus, configured
// through a shadow shift register that is applied atomically on a checked commit.
module sb_cfg_mux_array #(
    parameter int NUM_IN  = 10,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 4
) (
    input  logic               prog_clk,
    input  logic               pReset,
    input  logic               ccff_head,
    input  logic               ccff_shift_en,
    input  logic               ccff_commit,
    output logic               ccff_tail,
    output logic               cfg_valid,
    output logic               cfg_err,
    input  logic [NUM_IN-1:0]  in_bus,
    output logic [NUM_OUT-1:0] out_bus
);

    localparam int CHAIN_LEN = NUM_OUT * SEL_W + 1;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 2);
    localparam int FIELD_W   = NUM_OUT * SEL_W;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(CHAIN_LEN + 1);

    logic [CHAIN_LEN-1:0] shadow;
    logic [CNT_W-1:0]     count;
    logic [FIELD_W-1:0]   sel_act;
    logic                 commit_ok;

    // Bit counter stops one past a full frame so an over-long load stays detectable.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= CNT_OVF) ? CNT_OVF : c + CNT_W'(1);
    endfunction

    function automatic logic parity_ok(input logic [CHAIN_LEN-1:0] v);
        return ~(^v);
    endfunction

    assign commit_ok = (count == CNT_FULL) && parity_ok(shadow);
    assign ccff_tail = shadow[CHAIN_LEN-1];

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            shadow    <= '0;
            count     <= '0;
            sel_act   <= '0;
            cfg_valid <= 1'b0;
            cfg_err   <= 1'b0;
        end else if (ccff_commit) begin
            // Commit takes priority over a simultaneous shift; shadow is kept.
            count <= '0;
            if (commit_ok) begin
                sel_act   <= shadow[FIELD_W-1:0];
                cfg_valid <= 1'b1;
                cfg_err   <= 1'b0;
            end else begin
                cfg_err <= 1'b1;
            end
        end else if (ccff_shift_en) begin
            shadow <= {shadow[CHAIN_LEN-2:0], ccff_head};
            count  <= sat_inc(count);
        end
    end

    // Out-of-range selects match no input and therefore drive 0.
    always_comb begin
        out_bus = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (cfg_valid && (sel_act[j*SEL_W +: SEL_W] == SEL_W'(i))) begin
                    out_bus[j] = in_bus[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_sb_cfg_mux_array.sv
// Randomized scoreboard bench for sb_cfg_mux_array against a queue-based frame model.
module tb_sb_cfg_mux_array;

    localparam int NUM_IN  = 10;
    localparam int NUM_OUT = 4;
    localparam int SEL_W   = 4;
    localparam int CL      = NUM_OUT * SEL_W + 1;
    localparam int FW      = NUM_OUT * SEL_W;

    logic               prog_clk = 1'b0;
    logic               pReset = 1'b1;
    logic               ccff_head = 1'b0;
    logic               ccff_shift_en = 1'b0;
    logic               ccff_commit = 1'b0;
    logic               ccff_tail;
    logic               cfg_valid;
    logic               cfg_err;
    logic [NUM_IN-1:0]  in_bus = '0;
    logic [NUM_OUT-1:0] out_bus;

    sb_cfg_mux_array #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .SEL_W(SEL_W)) dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_commit   (ccff_commit),
        .ccff_tail     (ccff_tail),
        .cfg_valid     (cfg_valid),
        .cfg_err       (cfg_err),
        .in_bus        (in_bus),
        .out_bus       (out_bus)
    );

    always #5 prog_clk = ~prog_clk;

    typedef struct packed {
        logic               v;
        logic               e;
        logic               t;
        logic [NUM_OUT-1:0] o;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model: the last CL bits shifted in (oldest first), a plain bit
    // count, and the active selects as integers.
    bit m_hist[$];
    int m_cnt;
    bit m_valid;
    bit m_err;
    int m_sel[NUM_OUT];

    function automatic void model_reset();
        m_hist.delete();
        for (int i = 0; i < CL; i++) m_hist.push_back(1'b0);
        m_cnt   = 0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        for (int j = 0; j < NUM_OUT; j++) m_sel[j] = 0;
    endfunction

    // shadow[i] is the bit shifted in i shifts ago.
    function automatic bit m_shadow(int i);
        return m_hist[CL-1-i];
    endfunction

    function automatic void model_edge(bit sh, bit cm, bit hd);
        int x;
        if (cm) begin
            x = 0;
            for (int k = 0; k < CL; k++) x = x ^ int'(m_hist[k]);
            if (m_cnt == CL && x == 0) begin
                for (int j = 0; j < NUM_OUT; j++) begin
                    m_sel[j] = 0;
                    for (int b = 0; b < SEL_W; b++)
                        m_sel[j] = m_sel[j] + (int'(m_shadow(j*SEL_W + b)) << b);
                end
                m_valid = 1'b1;
                m_err   = 1'b0;
            end else begin
                m_err = 1'b1;
            end
            m_cnt = 0;
        end else if (sh) begin
            m_hist.push_back(hd);
            void'(m_hist.pop_front());
            if (m_cnt < CL + 1) m_cnt++;
        end
    endfunction

    function automatic exp_t model_out(logic [NUM_IN-1:0] ib);
        exp_t e;
        e.v = m_valid;
        e.e = m_err;
        e.t = m_hist[0];
        e.o = '0;
        for (int j = 0; j < NUM_OUT; j++)
            if (m_valid && m_sel[j] < NUM_IN) e.o[j] = ib[m_sel[j]];
        return e;
    endfunction

    function automatic logic [NUM_IN-1:0] rb();
        return NUM_IN'($urandom);
    endfunction

    function automatic logic [CL-1:0] make_frame(logic [FW-1:0] f);
        return {^f, f};
    endfunction

    // Drive one cycle of inputs, queue the expected outputs for this cycle,
    // then advance the model across the next rising edge.
    task automatic step(bit sh, bit cm, bit hd, bit r, logic [NUM_IN-1:0] ib);
        ccff_shift_en = sh;
        ccff_commit   = cm;
        ccff_head     = hd;
        in_bus        = ib;
        pReset        = r;
        if (r) model_reset();
        exp_q.push_back(model_out(ib));
        @(posedge prog_clk);
        if (!r) model_edge(sh, cm, hd);
        #1;
    endtask

    task automatic load(logic [CL-1:0] sv, int nbits);
        for (int k = CL - 1; k > CL - 1 - nbits; k--) step(1'b1, 1'b0, sv[k], 1'b0, rb());
    endtask

    task automatic shift_rand(int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'($urandom), 1'b0, rb());
    endtask

    task automatic commit();
        step(1'b0, 1'b1, 1'($urandom), 1'b0, rb());
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'($urandom), 1'b0, rb());
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    endtask

    exp_t mon_e;
    initial begin
        forever begin
            @(negedge prog_clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("cfg_valid", 32'(cfg_valid), 32'(mon_e.v));
                chk("cfg_err",   32'(cfg_err),   32'(mon_e.e));
                chk("ccff_tail", 32'(ccff_tail), 32'(mon_e.t));
                chk("out_bus",   32'(out_bus),   32'(mon_e.o));
            end
        end
    end

    logic [CL-1:0] good;
    logic [CL-1:0] good2;
    logic [CL-1:0] fr;
    int            mode;

    initial begin
        model_reset();
        repeat (2) @(posedge prog_clk);
        #1;
        step(1'b0, 1'b0, 1'b0, 1'b1, rb());
        idle(2);

        // asynchronous reset in the middle of a load
        shift_rand(7);
        step(1'b0, 1'b0, 1'b0, 1'b1, rb());

        good  = make_frame({4'd12, 4'd0, 4'd9, 4'd3});
        good2 = make_frame({4'd1, 4'd15, 4'd5, 4'd8});
        load(good, CL);
        commit();
        step(1'b0, 1'b0, 1'b0, 1'b0, 10'b10_0000_1001);
        idle(3);

        // bad parity keeps the previous configuration
        load(good ^ CL'(1), CL);
        commit();
        step(1'b0, 1'b0, 1'b0, 1'b0, 10'b10_0000_1001);
        idle(2);

        // short load, then good load
        load(good2, CL - 1);
        commit();
        load(good2, CL);
        commit();
        idle(2);

        // overflow load (shadow holds a valid frame but count is past full)
        shift_rand(1);
        load(good2, CL);
        commit();
        idle(1);
        load(good, CL);
        commit();
        idle(2);

        // shift and commit together after 16 shifts
        load(good2, CL - 1);
        step(1'b1, 1'b1, 1'($urandom), 1'b0, rb());
        idle(1);
        load(good2, CL);
        commit();
        idle(2);

        // pass-through without commit
        shift_rand(2 * CL);
        idle(2);

        // randomized frames, lengths, corruptions and collisions
        repeat (25) begin
            fr   = make_frame(FW'($urandom));
            mode = $urandom_range(0, 7);
            if (mode == 0) load(fr, $urandom_range(1, CL - 1));
            else if (mode == 1) begin shift_rand(1); load(fr, CL); end
            else if (mode == 2) load(fr ^ (CL'(1) << $urandom_range(0, CL - 1)), CL);
            else load(fr, CL);
            if (mode == 3) step(1'b1, 1'b1, 1'($urandom), 1'b0, rb());
            else commit();
            idle($urandom_range(1, 3));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge prog_clk);
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
